// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the instruction fetch front end
package fetch_pkg;

  localparam int FETCH_ADDR_WIDTH = 10;
  localparam int FETCH_DATA_WIDTH = 16;
  localparam int FETCH_BOOT_ADDR  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - control, program-load and fetch-output bundle of the fetch unit
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = FETCH_ADDR_WIDTH,
  parameter int DATA_WIDTH = FETCH_DATA_WIDTH
);

  logic                  load_start;
  logic [ADDR_WIDTH-1:0] load_base;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_end;
  logic                  run;
  logic                  halt;
  logic                  stall;
  logic                  branch;
  logic [ADDR_WIDTH-1:0] br_address;

  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] instr_out;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_valid;
  logic                  loading;
  logic                  running;
  logic                  load_wrapped;

  // Control side: drives modes, program words and pipeline control.
  modport master (
    output load_start, load_base, load_valid, load_data, load_end,
    output run, halt, stall, branch, br_address,
    input  pc, instr_out, instr_pc, instr_valid, loading, running, load_wrapped
  );

  // Fetch unit side.
  modport slave (
    input  load_start, load_base, load_valid, load_data, load_end,
    input  run, halt, stall, branch, br_address,
    output pc, instr_out, instr_pc, instr_valid, loading, running, load_wrapped
  );

endinterface

// File: rtl/fetch_mem.sv
// rtl/fetch_mem.sv - instruction RAM with one write port and one registered read port
module fetch_mem
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = FETCH_ADDR_WIDTH,
  parameter int DATA_WIDTH = FETCH_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array write; contents deliberately survive reset so a loaded program persists.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register; holds its word whenever the read port is not enabled (stall, bubble, idle).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, load pointer and run/halt FSM feeding instruction words to decode
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = FETCH_ADDR_WIDTH,
  parameter int DATA_WIDTH = FETCH_DATA_WIDTH,
  parameter int BOOT_ADDR  = FETCH_BOOT_ADDR
) (
  input logic    clk,
  input logic    reset,
  fetch_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] BOOT_PC = ADDR_WIDTH'(BOOT_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);

  fetch_state_e          state;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] ipc_q;
  logic                  valid_q;
  logic                  wrapped_q;
  logic                  loading_q;
  logic                  running_q;
  logic                  mem_we;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] instr_word;

  // Writes only while loading; reads only on a RUN edge that actually fetches.
  assign mem_we = (state == LOAD) && bus.load_valid;
  assign mem_re = (state == RUN) && !bus.halt && !bus.branch && !bus.stall;

  fetch_mem #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem (
    .clk  (clk),
    .reset(reset),
    .we   (mem_we),
    .waddr(ptr_q),
    .wdata(bus.load_data),
    .re   (mem_re),
    .raddr(pc_q),
    .rdata(instr_word)
  );

  // Mode FSM together with PC, load pointer and the fetch-stage valid/pc registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc_q      <= BOOT_PC;
      ptr_q     <= '0;
      ipc_q     <= '0;
      valid_q   <= 1'b0;
      wrapped_q <= 1'b0;
      loading_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.load_start) begin
            state     <= LOAD;
            loading_q <= 1'b1;
            ptr_q     <= bus.load_base;
            wrapped_q <= 1'b0;
          end else if (bus.run) begin
            state     <= RUN;
            running_q <= 1'b1;
            pc_q      <= BOOT_PC;
            valid_q   <= 1'b0;
          end
        end
        LOAD: begin
          // A word offered with load_end is still written before leaving LOAD.
          if (bus.load_valid) begin
            ptr_q <= ptr_q + ONE;
            if (&ptr_q) begin
              wrapped_q <= 1'b1;
            end
          end
          if (bus.load_end) begin
            state     <= IDLE;
            loading_q <= 1'b0;
          end
        end
        RUN: begin
          if (bus.halt) begin
            state     <= IDLE;
            running_q <= 1'b0;
            valid_q   <= 1'b0;
          end else if (bus.branch) begin
            // Redirect and drop the word that would have been fetched this edge.
            pc_q    <= bus.br_address;
            valid_q <= 1'b0;
          end else if (!bus.stall) begin
            ipc_q   <= pc_q;
            valid_q <= 1'b1;
            pc_q    <= pc_q + ONE;
          end
        end
        default: begin
          state     <= IDLE;
          loading_q <= 1'b0;
          running_q <= 1'b0;
          valid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc           = pc_q;
  assign bus.instr_out    = instr_word;
  assign bus.instr_pc     = ipc_q;
  assign bus.instr_valid  = valid_q;
  assign bus.loading      = loading_q;
  assign bus.running      = running_q;
  assign bus.load_wrapped = wrapped_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit against a transaction-level model
module tb_fetch_unit;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int BOOT  = 0;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fetch_unit #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .BOOT_ADDR (BOOT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int unsigned pc;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] ld_q[$];
  int          m_state;
  int unsigned m_pc;
  int unsigned m_ptr;
  int unsigned m_ipc;
  logic [15:0] m_iout;
  bit          m_valid;
  bit          m_wrapped;
  logic [15:0] m_mem [DEPTH];
  bit          mon_en = 0;
  exp_t        e;

  task automatic model_reset();
    m_state   = M_IDLE;
    m_pc      = BOOT;
    m_ptr     = 0;
    m_ipc     = 0;
    m_iout    = '0;
    m_valid   = 0;
    m_wrapped = 0;
  endtask

  // One clock of the processor as seen from the outside, using the inputs currently driven.
  task automatic model_step();
    case (m_state)
      M_IDLE: begin
        if (bus.load_start) begin
          m_state   = M_LOAD;
          m_ptr     = int'(bus.load_base);
          m_wrapped = 0;
        end else if (bus.run) begin
          m_state = M_RUN;
          m_pc    = BOOT;
          m_valid = 0;
        end
      end
      M_LOAD: begin
        if (bus.load_valid) begin
          m_mem[m_ptr] = bus.load_data;
          if (m_ptr == DEPTH - 1) m_wrapped = 1;
          m_ptr = (m_ptr + 1) % DEPTH;
        end
        if (bus.load_end) m_state = M_IDLE;
      end
      M_RUN: begin
        if (bus.halt) begin
          m_state = M_IDLE;
          m_valid = 0;
        end else if (bus.branch) begin
          m_pc    = int'(bus.br_address);
          m_valid = 0;
        end else if (!bus.stall) begin
          m_iout  = m_mem[m_pc];
          m_ipc   = m_pc;
          m_valid = 1;
          m_pc    = (m_pc + 1) % DEPTH;
        end
      end
      default: ;
    endcase
    if (m_valid) exp_q.push_back('{m_ipc, m_iout});
  endtask

  task automatic clear_inputs();
    bus.load_start = 1'b0;
    bus.load_base  = '0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_end   = 1'b0;
    bus.run        = 1'b0;
    bus.halt       = 1'b0;
    bus.stall      = 1'b0;
    bus.branch     = 1'b0;
    bus.br_address = '0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Loads ld_q from base; optionally folds load_end into the last write and jiggles run.
  task automatic load_program(input int unsigned base, input bit end_with_last, input bit noisy);
    bus.load_start = 1'b1;
    bus.load_base  = AW'(base);
    tick();
    bus.load_start = 1'b0;
    while (ld_q.size() > 0) begin
      bus.load_valid = 1'b1;
      bus.load_data  = ld_q.pop_front();
      bus.run        = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.load_end   = (end_with_last && ld_q.size() == 0);
      tick();
    end
    bus.load_valid = 1'b0;
    bus.run        = 1'b0;
    if (m_state == M_LOAD) begin
      bus.load_end = 1'b1;
      tick();
    end
    bus.load_end = 1'b0;
  endtask

  task automatic start_run();
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
  endtask

  task automatic do_halt();
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
  endtask

  // Monitor: steady-state outputs every cycle, and the fetch stream whenever a word is presented.
  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      check("loading", 32'(bus.loading), 32'(m_state == M_LOAD));
      check("running", 32'(bus.running), 32'(m_state == M_RUN));
      check("pc", 32'(bus.pc), m_pc);
      check("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
      check("load_wrapped", 32'(bus.load_wrapped), 32'(m_wrapped));
      if (bus.instr_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fetch_unexpected: instr_pc=0x%0h instr_out=0x%0h, no fetch expected", bus.instr_pc, bus.instr_out);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", 32'(bus.instr_pc), e.pc);
          check("instr_out", 32'(bus.instr_out), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_loading", 32'(bus.loading), 0);
    check("rst_running", 32'(bus.running), 0);
    check("rst_pc", 32'(bus.pc), BOOT);
    check("rst_instr_out", 32'(bus.instr_out), 0);
    check("rst_instr_pc", 32'(bus.instr_pc), 0);
    check("rst_instr_valid", 32'(bus.instr_valid), 0);
    check("rst_load_wrapped", 32'(bus.load_wrapped), 0);
    reset  = 1'b0;
    mon_en = 1;

    // Fill the whole array so every fetch address has known contents; wraps at the end.
    for (int i = 0; i < DEPTH; i++) ld_q.push_back(16'($urandom));
    load_program(0, 0, 0);

    // Load then run, with a 3-cycle stall while instr_pc is 1.
    ld_q = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    load_program(0, 0, 0);
    start_run();
    repeat (2) tick();
    bus.stall = 1'b1;
    repeat (3) tick();
    bus.stall = 1'b0;
    repeat (2) tick();
    do_halt();

    // Branch to 3 while pc is 1, then the same with stall held alongside.
    for (int k = 0; k < 2; k++) begin
      start_run();
      tick();
      bus.branch     = 1'b1;
      bus.stall      = k[0];
      bus.br_address = 4'h3;
      tick();
      bus.branch = 1'b0;
      bus.stall  = 1'b0;
      repeat (2) tick();
      do_halt();
    end

    // Wrapping load from 0xE, then branch to 0xE and fetch across the top of memory.
    ld_q = '{16'hA0E0, 16'hA0F0, 16'hA000, 16'hA010};
    load_program(4'hE, 1, 0);
    start_run();
    bus.branch     = 1'b1;
    bus.br_address = 4'hE;
    tick();
    bus.branch = 1'b0;
    repeat (5) tick();
    do_halt();

    // Asynchronous reset in the middle of a load after two writes.
    bus.load_start = 1'b1;
    bus.load_base  = 4'h5;
    tick();
    bus.load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 16'h5500 + 16'(i);
      tick();
    end
    bus.load_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_rst_loading", 32'(bus.loading), 0);
    check("async_rst_pc", 32'(bus.pc), BOOT);
    check("async_rst_instr_valid", 32'(bus.instr_valid), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    start_run();
    repeat (8) tick();
    do_halt();

    // Mode isolation: load traffic during RUN, run toggling during LOAD.
    start_run();
    for (int i = 0; i < 6; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 16'hDEAD;
      bus.load_end   = i[0];
      tick();
    end
    clear_inputs();
    do_halt();
    repeat (2) tick();
    for (int i = 0; i < 3; i++) ld_q.push_back(16'($urandom));
    load_program(4'h2, 0, 1);
    start_run();
    repeat (8) tick();
    do_halt();

    // Randomised loads and runs with stall, branch, halt and stray load traffic.
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < int'($urandom_range(0, 5)); i++) ld_q.push_back(16'($urandom));
      load_program($urandom_range(0, DEPTH - 1), 1'($urandom_range(0, 1)), 1);
      start_run();
      for (int c = 0; c < 30; c++) begin
        bus.stall      = ($urandom_range(0, 3) == 0);
        bus.branch     = ($urandom_range(0, 7) == 0);
        bus.br_address = AW'($urandom_range(0, DEPTH - 1));
        bus.halt       = ($urandom_range(0, 31) == 0);
        bus.load_valid = 1'($urandom_range(0, 1));
        bus.load_data  = 16'($urandom);
        bus.load_end   = ($urandom_range(0, 7) == 0);
        tick();
      end
      clear_inputs();
      if (m_state != M_IDLE) begin
        bus.halt     = 1'b1;
        bus.load_end = 1'b1;
        tick();
        clear_inputs();
      end
    end

    repeat (2) tick();
    mon_en = 0;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch front end. It merges the program counter, the PC incrementer and the instruction memory into one block, and adds a program-load mode, a run/halt control FSM, a one-cycle synchronous fetch pipeline and branch flush. It sits at the head of the processor pipeline and feeds instruction words, with a valid flag and the matching PC, to decode.

Parameters:
ADDR_WIDTH, 10, width of PC, load pointer and memory address; memory depth is 2**ADDR_WIDTH words.
DATA_WIDTH, 16, instruction word width.
BOOT_ADDR, 0, PC value loaded on reset and on every entry to RUN.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-high; clears all state except memory contents.
load_start  in  1  IDLE only: enter LOAD; load pointer <= load_base.
load_base  in  ADDR_WIDTH  first address written in LOAD.
load_valid  in  1  LOAD only: write load_data at the load pointer, then pointer+1.
load_data  in  DATA_WIDTH  word to write.
load_end  in  1  LOAD only: return to IDLE.
run  in  1  IDLE only: enter RUN; PC <= BOOT_ADDR.
halt  in  1  RUN only: return to IDLE.
stall  in  1  RUN: freeze PC and fetch outputs.
branch  in  1  RUN: redirect PC to br_address and flush the in-flight fetch.
br_address  in  ADDR_WIDTH  branch target.
pc  out  ADDR_WIDTH  current fetch address.
instr_out  out  DATA_WIDTH  fetched instruction (registered).
instr_pc  out  ADDR_WIDTH  address instr_out was read from.
instr_valid  out  1  instr_out is a valid, non-flushed instruction.
loading  out  1  state == LOAD.
running  out  1  state == RUN.
load_wrapped  out  1  sticky: the load pointer wrapped past 2**ADDR_WIDTH-1 during this LOAD.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, pc=BOOT_ADDR, instr_out=0, instr_pc=0, instr_valid=0.
  - loading=0, running=0, load_wrapped=0, load pointer=0.
  - Memory array is not cleared.
- FSM states are IDLE, LOAD and RUN.
  - IDLE: load_start -> LOAD. Otherwise run -> RUN. load_start has priority if both are high.
  - LOAD: load_end -> IDLE.
  - RUN: halt -> IDLE.
  - Inputs not listed for the current state are ignored.
- LOAD:
  - On each load_valid: mem[ptr] <= load_data; ptr <= ptr+1 modulo 2**ADDR_WIDTH.
  - A wrap from all-ones to 0 sets load_wrapped. load_wrapped clears on the next load_start.
  - load_valid together with load_end: the write completes, then the FSM goes to IDLE.
  - instr_valid stays 0.
- RUN entry: pc <= BOOT_ADDR and instr_valid=0 in the first RUN cycle.
- RUN fetch (synchronous read, latency 1). Each non-stalled edge does:
  - instr_out <= mem[pc];
  - instr_pc <= pc;
  - instr_valid <= 1;
  - pc <= pc+1 modulo 2**ADDR_WIDTH, so all-ones wraps to 0.
- stall=1, branch=0: pc, instr_out, instr_pc and instr_valid all hold.
- branch=1: pc <= br_address and instr_valid <= 0, a one-cycle bubble.
  - Branch wins over stall.
  - The target instruction appears one cycle later with instr_valid=1.
- halt: next state IDLE, instr_valid <= 0, pc holds.
- Outside RUN, instr_valid=0 and pc does not advance.
- Reset mid-LOAD or mid-RUN: immediate return to IDLE with the reset values above. Words already written stay in memory.
- All address arithmetic is unsigned, ADDR_WIDTH bits, with no overflow flag except load_wrapped.

Decomposition:
- Shared package fetch_pkg:
  - state enum {IDLE, LOAD, RUN};
  - default ADDR_WIDTH and DATA_WIDTH localparams;
  - BOOT_ADDR default.
- Sub-module fetch_mem: single-port-write, single-read synchronous RAM parametrised by ADDR_WIDTH and DATA_WIDTH. The write port is driven only in LOAD and the read port only in RUN.
- The PC, its incrementer and the FSM stay in fetch_unit.

Test Plan:
1. Load then run: load_base=0x000, write 0x0011, 0x0022, 0x0033, 0x0044, load_end, run. Required outputs: instr_valid low for the first RUN cycle, then (instr_pc, instr_out) = (0,0x0011), (1,0x0022), (2,0x0033), (3,0x0044) on consecutive cycles.
2. Stall: during the run of scenario 1, hold stall high for 3 cycles while instr_pc=1. Required: pc=2, instr_out=0x0022, instr_valid=1 held for 3 cycles, then the sequence resumes with 0x0033.
3. Branch: br_address=0x003 with branch for 1 cycle while pc=1. Required: next cycle instr_valid=0, the cycle after (3,0x0044). Branch asserted together with stall behaves identically.
4. Wrap: ADDR_WIDTH=4, load_base=0xE, write 4 words. Required: load_wrapped=1 and words land at 0xE, 0xF, 0x0, 0x1. Then branch to 0xE: instr_pc sequence 0xE, 0xF, 0x0, 0x1.
5. Reset mid-operation: assert reset asynchronously mid-LOAD after 2 writes. Required: loading=0 immediately, pc=BOOT_ADDR, instr_valid=0. Then run without reloading: the 2 written words are fetched intact.
6. Mode isolation: load_valid during RUN does not alter memory. Toggling run during LOAD has no effect. halt during RUN -> running=0, instr_valid=0 and pc frozen.
